// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder
//
// Instruction-fetch responder between the program counter and the decode stage.
// It takes word-address fetch requests over a valid/ready handshake and reads a
// synchronous instruction memory that has one cycle of read latency. Each
// instruction comes back in request order through a small response FIFO. An
// address that lies outside the memory is not read; it returns a zero
// instruction with the fault flag set. When the consumer never stalls, the block
// sustains one fetch per cycle.
//
// Parameters
//   DEPTH_LOG2  instruction memory holds 2**DEPTH_LOG2 32-bit words
//   BUF_DEPTH   response FIFO entries (2..8; 3 or more gives full throughput)
//
// Ports
//   CLK        in   clock; all state updates on the rising edge
//   RST        in   synchronous active-low reset
//   REQ_VALID  in   fetch request present
//   REQ_ADDR   in   32-bit word address (PC value)
//   REQ_READY  out  request accepted when REQ_VALID && REQ_READY
//   FLUSH      in   drop every in-flight and buffered fetch (branch redirect)
//   MEM_EN     out  memory read strobe
//   MEM_ADDR   out  memory word index
//   MEM_RDATA  in   memory data, valid the cycle after MEM_EN
//   RSP_VALID  out  FIFO head valid
//   RSP_INSTR  out  instruction at FIFO head (0 when empty or faulted)
//   RSP_ADDR   out  request address of the head entry (0 when empty)
//   RSP_FAULT  out  head entry address was out of range (0 when empty)
//   RSP_READY  in   consumer takes the head when RSP_VALID && RSP_READY

module instr_fetch_responder #(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned BUF_DEPTH  = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   input  logic [31:0]           REQ_ADDR,
   output logic                  REQ_READY,
   input  logic                  FLUSH,
   output logic                  MEM_EN,
   output logic [DEPTH_LOG2-1:0] MEM_ADDR,
   input  logic [31:0]           MEM_RDATA,
   output logic                  RSP_VALID,
   output logic [31:0]           RSP_INSTR,
   output logic [31:0]           RSP_ADDR,
   output logic                  RSP_FAULT,
   input  logic                  RSP_READY
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   // Memory size held at 33 bits, so the range check needs no truncation at any DEPTH_LOG2.
   localparam logic [32:0]      MEM_WORDS = 33'd1 << DEPTH_LOG2;
   localparam logic [CNT_W:0]   BUF_LIMIT = (CNT_W + 1)'(BUF_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);

   // Request decode
   logic             req_fault;
   logic             accept;
   logic [CNT_W:0]   occupancy;

   // Stage S1: request whose memory read is in flight
   logic             s1_valid;
   logic [31:0]      s1_addr;
   logic             s1_fault;

   // Response FIFO
   logic [31:0]      fifo_instr [0:BUF_DEPTH-1];
   logic [31:0]      fifo_addr  [0:BUF_DEPTH-1];
   logic             fifo_fault [0:BUF_DEPTH-1];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
   endfunction

   // Ready counts the entry still in S1, so a push never lands in a full FIFO.
   // RSP_READY does not feed back into this path.
   always_comb begin
      occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid);
      REQ_READY = RST && !FLUSH && (occupancy < BUF_LIMIT);
      req_fault = ({1'b0, REQ_ADDR} >= MEM_WORDS);
      accept    = REQ_VALID && REQ_READY;
      MEM_EN    = accept && !req_fault;
      MEM_ADDR  = REQ_ADDR[DEPTH_LOG2-1:0];
   end

   assign push = s1_valid;
   assign pop  = (fifo_count != '0) && RSP_READY;

   always_ff @(posedge CLK) begin
      if (!RST || FLUSH) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_fault <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_addr  <= REQ_ADDR;
            s1_fault <= req_fault;
         end
      end
   end

   // Storage is left without a reset: every read of it is gated by fifo_count.
   always_ff @(posedge CLK) begin
      if (RST && !FLUSH && push) begin
         fifo_instr[wr_ptr] <= s1_fault ? 32'h0 : MEM_RDATA;
         fifo_addr[wr_ptr]  <= s1_addr;
         fifo_fault[wr_ptr] <= s1_fault;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST || FLUSH) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_comb begin
      RSP_VALID = 1'b0;
      RSP_INSTR = '0;
      RSP_ADDR  = '0;
      RSP_FAULT = 1'b0;
      if (fifo_count != '0) begin
         RSP_VALID = 1'b1;
         RSP_INSTR = fifo_instr[rd_ptr];
         RSP_ADDR  = fifo_addr[rd_ptr];
         RSP_FAULT = fifo_fault[rd_ptr];
      end
   end

endmodule
